amo_sequencer: RTL and testbench
================================

# amo_sequencer

Multi-cycle sequencer for RV32A instructions (LR.W, SC.W, AMO*.W) between the execute stage and the data-memory port. It owns the single-hart load-reservation register and performs the read-modify-write sequence. It returns one 32-bit result per accepted request. It holds the data bus exclusively for the duration of each operation.

## Interface
- No parameters; data and address width are fixed at 32.
- clk  in  1  core clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents an atomic instruction.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_funct5  in  5  instruction bits [31:27]. aq/rl bits are not used.
- req_addr  in  32  effective address (rs1).
- req_wdata  in  32  rs2 operand.
- resp_valid  out  1  one-cycle pulse carrying the result.
- resp_rdata  out  32  value written to rd.
- resp_err  out  1  misaligned address or unknown funct5; qualified by resp_valid.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid with mem_ack on reads.
- mem_ack  in  1  completes the current bus beat.
- snoop_valid  in  1  another master wrote memory.
- snoop_addr  in  32  word address of that write.
- flush  in  1  trap or context switch; clears the reservation.

## Operation
- States: IDLE, RD, WR, DONE.
- funct5 decode:
  - 00010 = LR
  - 00011 = SC
  - 00001 = SWAP
  - 00000 = ADD
  - 00100 = XOR
  - 01100 = AND
  - 01000 = OR
  - 10000 = MIN
  - 10100 = MAX
  - 11000 = MINU
  - 11100 = MAXU
- On accept, the sequencer latches funct5, address and rs2.
- Error path: req_addr[1:0] != 0 or unknown funct5.
  - Transition IDLE→DONE; resp_err=1, resp_rdata=0.
  - No bus access; reservation unchanged.
- LR: IDLE→RD. On ack, resv_valid=1, resv_addr=addr[31:2], rdata=mem_rdata; then →DONE.
- SC success requires resv_valid and resv_addr==addr[31:2] at accept.
  - Success: IDLE→WR, write rs2, rdata=0.
  - Failure: IDLE→DONE, rdata=1, no bus access.
  - Both outcomes clear resv_valid at accept.
- AMO: IDLE→RD, then latch old=mem_rdata, →WR.
  - Write alu(old, rs2); rdata=old; then →DONE.
  - Any AMO clears resv_valid at accept.
- ALU rules:
  - ADD is modulo 2^32.
  - MIN/MAX compare as signed 32-bit; MINU/MAXU as unsigned.
  - SWAP returns rs2.
- DONE: resp_valid=1 for exactly one cycle, then →IDLE.
- Snoop: snoop_valid with snoop_addr[31:2]==resv_addr clears resv_valid in any state.
- flush clears resv_valid in any state. It never aborts a bus transaction in progress.
- Reservation set and clear in the same cycle: an LR ack coinciding with a matching snoop or flush leaves resv_valid=0 (clear wins).

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - resv_valid=0.
- Reset during RD or WR drops mem_req immediately; the bus must tolerate the abandoned beat.
- mem_req, mem_we, mem_addr and mem_wdata are registered. They stay stable from assertion through the cycle mem_ack is seen.
- mem_ack outside RD or WR is ignored.
- A request is accepted in cycle 0 (req_valid && req_ready). Minimum latency to resp_valid, with mem_ack returned the same cycle mem_req rises:
  - AMO: cycle 3.
  - LR: cycle 2.
  - SC success: cycle 2.
  - SC failure or error: cycle 1.
- Each cycle mem_ack is late adds one cycle.
- Back-to-back requests: the next accept occurs no earlier than the cycle after resp_valid.
- An SC accepted in the same cycle as a matching snoop fails.

## Structure
- Shared pkg additions:
  - amo_op_e enum with the funct5 values above.
  - OPCODE_ATOMIC, if not already defined.
  - amo_state_e enum.
- Sub-module amo_alu: purely combinational; inputs op, old, rs2; output new value.
- All sequencing and the reservation register live in amo_sequencer.

## Test plan
- LR then SC, no interference. Bus responds 0x12345678. Then SC rs2=0xCAFEBABE → one write of 0xCAFEBABE, resp_rdata=0.
- LR, matching snoop, then SC → SC resp_rdata=1, no mem_req.
- AMOADD.W: old=0xFFFFFFFF, rs2=2 → write 0x00000001, resp_rdata=0xFFFFFFFF. Zero-wait ack gives resp_valid at cycle 3.
- AMOMIN.W vs AMOMINU.W: old=0x80000000, rs2=1 → MIN writes 0x80000000; MINU writes 0x00000001.
- Misaligned AMOSWAP at 0x1002 → resp_err=1 at cycle 1, no mem_req. funct5=11111 behaves the same.
- Reset mid-WR with mem_ack stalled 5 cycles → mem_req drops immediately, resv_valid=0. The next LR works normally.

Source files
------------

// File: rtl/amo_sequencer_pkg.sv
// Shared types for the RV32A atomic sequencer: opcode, funct5 operation codes,
// sequencer states and a decode helper.
package amo_sequencer_pkg;

  localparam logic [6:0] OPCODE_ATOMIC = 7'b0101111;
  localparam int         XLEN          = 32;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } amo_state_e;

  // True for every funct5 the sequencer implements; anything else is an error.
  function automatic logic amo_op_known(input logic [4:0] funct5);
    case (funct5)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write operator for AMO*.W: new memory value from
// the old memory word and the rs2 operand.
module amo_alu
  import amo_sequencer_pkg::*;
(
  input  amo_op_e     op,
  input  logic [31:0] old,
  input  logic [31:0] rs2,
  output logic [31:0] result
);

  always_comb begin
    result = rs2;
    case (op)
      AMO_ADD:  result = old + rs2;
      AMO_SWAP: result = rs2;
      AMO_XOR:  result = old ^ rs2;
      AMO_AND:  result = old & rs2;
      AMO_OR:   result = old | rs2;
      AMO_MIN:  result = ($signed(old) < $signed(rs2)) ? old : rs2;
      AMO_MAX:  result = ($signed(old) > $signed(rs2)) ? old : rs2;
      AMO_MINU: result = (old < rs2) ? old : rs2;
      AMO_MAXU: result = (old > rs2) ? old : rs2;
      default:  result = rs2;
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// RV32A sequencer: accepts one LR/SC/AMO at a time, runs the bus read and/or
// write beats, owns the load reservation and returns one result per request.
module amo_sequencer
  import amo_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_funct5,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        snoop_valid,
  input  logic [31:0] snoop_addr,
  input  logic        flush,
  output amo_state_e  dbg_state,
  output logic        dbg_resv_valid
);

  // Handshakes: a request transfers on the clk edge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with no back-pressure; a bus beat holds
  // mem_req/mem_we/mem_addr/mem_wdata stable and completes on the edge mem_ack is seen.

  amo_state_e  state, state_d;
  amo_op_e     req_op, op_q;
  logic [29:0] word_q;
  logic [31:0] rs2_q;
  logic [31:0] alu_result;

  logic        resv_valid;
  logic [29:0] resv_addr;

  logic        accept;
  logic        req_bad;
  logic        snoop_hit;
  logic        sc_ok;
  logic        lr_set;
  logic        resv_clr;
  logic        unused_snoop_lsb;

  assign req_op    = amo_op_e'(req_funct5);
  assign req_bad   = (req_addr[1:0] != 2'b00) || !amo_op_known(req_funct5);
  assign snoop_hit = snoop_valid && (snoop_addr[31:2] == resv_addr);

  // A snoop or flush landing in the accept cycle already kills the reservation.
  assign sc_ok = resv_valid && (resv_addr == req_addr[31:2]) && !snoop_hit && !flush;

  assign unused_snoop_lsb = ^snoop_addr[1:0];

  amo_alu u_alu (
    .op     (op_q),
    .old    (mem_rdata),
    .rs2    (rs2_q),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_bad) begin
            state_d = ST_DONE;
          end else if (req_op == AMO_SC) begin
            state_d = sc_ok ? ST_WR : ST_DONE;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          state_d = (op_q == AMO_LR) ? ST_DONE : ST_WR;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, bus outputs and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= AMO_ADD;
      word_q     <= '0;
      rs2_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (accept) begin
      op_q       <= req_op;
      word_q     <= req_addr[31:2];
      rs2_q      <= req_wdata;
      resp_err   <= req_bad;
      resp_rdata <= (!req_bad && (req_op == AMO_SC) && !sc_ok) ? 32'd1 : 32'd0;
      if ((state_d == ST_RD) || (state_d == ST_WR)) begin
        mem_req   <= 1'b1;
        mem_we    <= (state_d == ST_WR);
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= req_wdata;
      end
    end else if ((state == ST_RD) && mem_ack) begin
      // The old value is the result for both LR and AMO; AMO rolls straight into its write beat.
      resp_rdata <= mem_rdata;
      if (op_q == AMO_LR) begin
        mem_req <= 1'b0;
      end else begin
        mem_we    <= 1'b1;
        mem_wdata <= alu_result;
      end
    end else if ((state == ST_WR) && mem_ack) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  assign lr_set   = (state == ST_RD) && mem_ack && (op_q == AMO_LR);
  assign resv_clr = flush || snoop_hit || (accept && !req_bad && (req_op != AMO_LR));

  // Clear wins over set: a flush or snoop on the LR's own word during its ack leaves no reservation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (lr_set) begin
      resv_addr  <= word_q;
      resv_valid <= !(flush || (snoop_valid && (snoop_addr[31:2] == word_q)));
    end else if (resv_clr) begin
      resv_valid <= 1'b0;
    end
  end

  assign req_ready      = (state == ST_IDLE);
  assign resp_valid     = (state == ST_DONE);
  assign dbg_state      = state;
  assign dbg_resv_valid = resv_valid;

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: directed scenarios plus randomized LR/SC/AMO traffic
// checked against a transaction-level model of memory and the reservation.
module tb_amo_sequencer;
  import amo_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_funct5 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        flush = 1'b0;
  amo_state_e  dbg_state;
  logic        dbg_resv_valid;

  always #5 clk = ~clk;

  amo_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_funct5     (req_funct5),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .snoop_valid    (snoop_valid),
    .snoop_addr     (snoop_addr),
    .flush          (flush),
    .dbg_state      (dbg_state),
    .dbg_resv_valid (dbg_resv_valid)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] bus_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [63:0] wr_log[$];
  logic [63:0] exp_q[$];

  int          ack_delay  = 0;
  int          wait_cnt   = 0;
  int          rd_beats   = 0;
  int          req_cycles = 0;
  int          bad_align  = 0;
  logic        beat_we    = 1'b0;
  logic [31:0] beat_addr  = '0;
  logic [31:0] beat_wdata = '0;

  logic        m_rv = 1'b0;
  logic [29:0] m_ra = '0;

  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  logic [63:0] last_wr;

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] bus_read(input logic [29:0] w);
    if (!bus_mem.exists(w)) bus_mem[w] = init_val(w);
    return bus_mem[w];
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] w);
    if (!ref_mem.exists(w)) ref_mem[w] = init_val(w);
    return ref_mem[w];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f)
      5'b00000: return a + b;
      5'b00001: return b;
      5'b00100: return a ^ b;
      5'b01100: return a & b;
      5'b01000: return a | b;
      5'b10000: return (sa < sb) ? a : b;
      5'b10100: return (sa > sb) ? a : b;
      5'b11000: return (a < b) ? a : b;
      5'b11100: return (a > b) ? a : b;
      default:  return 32'h0;
    endcase
  endfunction

  // ---------------- bus responder (memory with configurable ack delay) ----------------
  always @(negedge clk) begin
    if (mem_ack) begin
      if (beat_we) begin
        bus_mem[beat_addr[31:2]] = beat_wdata;
        wr_log.push_back({beat_addr, beat_wdata});
      end else begin
        rd_beats++;
      end
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
    if (mem_req) begin
      req_cycles++;
      if (mem_addr[1:0] != 2'b00) bad_align++;
      if (wait_cnt >= ack_delay) begin
        mem_ack    = 1'b1;
        beat_we    = mem_we;
        beat_addr  = mem_addr;
        beat_wdata = mem_wdata;
        mem_rdata  = mem_we ? 32'hDEAD_0000 : bus_read(mem_addr[31:2]);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    bus_mem[addr[31:2]] = val;
    ref_mem[addr[31:2]] = val;
  endtask

  // One idle cycle, optionally with a snoop and/or flush.
  task automatic idle_cycle(input logic snp, input logic [31:0] snp_a, input logic flu);
    snoop_valid = snp;
    snoop_addr  = snp_a;
    flush       = flu;
    if (flu) m_rv = 1'b0;
    if (snp && (snp_a[31:2] == m_ra)) m_rv = 1'b0;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
    flush       = 1'b0;
  endtask

  // ---------------- driver + model for one request ----------------
  // snoop_at / flush_at: cycle index (0 = accept cycle) at which to pulse, -1 for none.
  task automatic run_op(input logic [4:0] f, input logic [31:0] addr, input logic [31:0] wdata,
                        input int d, input int snoop_at, input logic [31:0] snoop_a,
                        input int flush_at);
    logic [29:0] w;
    logic        bad;
    logic [31:0] e_rdata;
    logic [31:0] old_v;
    logic [31:0] new_v;
    logic        e_err;
    int          e_lat;
    int          exp_rd;
    int          rd0;
    int          rq0;
    int          cyc;
    logic        got;

    w      = addr[31:2];
    bad    = (addr[1:0] != 2'b00) ||
             !(f inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
                         5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100});
    exp_q.delete();
    exp_rd = 0;
    e_err  = 1'b0;

    if (flush_at == 0) m_rv = 1'b0;
    if ((snoop_at == 0) && (snoop_a[31:2] == m_ra)) m_rv = 1'b0;

    if (bad) begin
      e_err   = 1'b1;
      e_rdata = 32'h0;
      e_lat   = 1;
      if (flush_at >= 1) m_rv = 1'b0;
      if ((snoop_at >= 1) && (snoop_a[31:2] == m_ra)) m_rv = 1'b0;
    end else if (f == 5'b00010) begin
      e_rdata = ref_read(w);
      e_lat   = 2 + d;
      exp_rd  = 1;
      m_rv    = 1'b1;
      m_ra    = w;
      if (flush_at >= 1 + d) m_rv = 1'b0;
      if ((snoop_at >= 1 + d) && (snoop_a[31:2] == w)) m_rv = 1'b0;
    end else if (f == 5'b00011) begin
      if (m_rv && (m_ra == w)) begin
        ref_mem[w] = wdata;
        exp_q.push_back({w, 2'b00, wdata});
        e_rdata = 32'h0;
        e_lat   = 2 + d;
      end else begin
        e_rdata = 32'h1;
        e_lat   = 1;
      end
      m_rv = 1'b0;
    end else begin
      old_v      = ref_read(w);
      new_v      = ref_alu(f, old_v, wdata);
      ref_mem[w] = new_v;
      exp_q.push_back({w, 2'b00, new_v});
      e_rdata    = old_v;
      e_lat      = 3 + 2 * d;
      exp_rd     = 1;
      m_rv       = 1'b0;
    end

    ack_delay = d;
    wr_log.delete();
    rd0 = rd_beats;
    rq0 = req_cycles;

    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_funct5  = f;
    req_addr    = addr;
    req_wdata   = wdata;
    snoop_valid = (snoop_at == 0);
    snoop_addr  = snoop_a;
    flush       = (flush_at == 0);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_funct5 = 5'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    cyc = 1;
    got = 1'b0;
    while (cyc <= 40) begin
      snoop_valid = (snoop_at == cyc);
      flush       = (flush_at == cyc);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("resp_seen", 32'(got), 32'd1);
    last_rdata = resp_rdata;
    last_err   = resp_err;
    last_lat   = cyc;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
    flush       = 1'b0;
    last_wr     = (wr_log.size() > 0) ? wr_log[0] : 64'hFFFF_FFFF_FFFF_FFFF;

    check("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
    check("resp_rdata", last_rdata, e_rdata);
    check("resp_err", 32'(last_err), 32'(e_err));
    check("latency", 32'(last_lat), 32'(e_lat));
    check("write_count", 32'(wr_log.size()), 32'(exp_q.size()));
    while ((exp_q.size() > 0) && (wr_log.size() > 0)) begin
      check("write_addr", wr_log[0][63:32], exp_q[0][63:32]);
      check("write_data", wr_log[0][31:0], exp_q[0][31:0]);
      void'(wr_log.pop_front());
      void'(exp_q.pop_front());
    end
    check("read_count", 32'(rd_beats - rd0), 32'(exp_rd));
    if (exp_rd == 0 && e_lat == 1) check("no_mem_req", 32'(req_cycles - rq0), 32'd0);
    check("resv_valid", 32'(dbg_resv_valid), 32'(m_rv));
  endtask

  // ---------------- stimulus ----------------
  logic [4:0]  op_tab  [13];
  logic [31:0] addr_pool[4];

  initial begin
    int          k;
    int          d;
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] wd;
    int          s_at;
    int          f_at;

    op_tab = '{5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
               5'b10000, 5'b10100, 5'b11000, 5'b11100, 5'b00010, 5'b00011};
    addr_pool = '{32'h0000_1000, 32'h0000_1004, 32'h0000_2000, 32'h0000_3FFC};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mem_req", 32'(mem_req), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resv_valid", 32'(dbg_resv_valid), 32'd0);

    // LR then SC, undisturbed
    set_word(32'h0000_0100, 32'h1234_5678);
    run_op(5'b00010, 32'h0000_0100, 32'h0, 0, -1, 32'h0, -1);
    check("tp_lr_data", last_rdata, 32'h1234_5678);
    check("tp_lr_lat", 32'(last_lat), 32'd2);
    run_op(5'b00011, 32'h0000_0100, 32'hCAFE_BABE, 0, -1, 32'h0, -1);
    check("tp_sc_rdata", last_rdata, 32'h0);
    check("tp_sc_wdata", last_wr[31:0], 32'hCAFE_BABE);

    // LR, matching snoop while idle, SC fails without touching the bus
    run_op(5'b00010, 32'h0000_0200, 32'h0, 1, -1, 32'h0, -1);
    idle_cycle(1'b1, 32'h0000_0203, 1'b0);
    run_op(5'b00011, 32'h0000_0200, 32'h1111_2222, 0, -1, 32'h0, -1);
    check("tp_sc_fail_rdata", last_rdata, 32'h1);

    // Snoop coinciding with the LR ack, then snoop in the SC accept cycle
    run_op(5'b00010, 32'h0000_0240, 32'h0, 0, 1, 32'h0000_0240, -1);
    run_op(5'b00010, 32'h0000_0240, 32'h0, 2, -1, 32'h0, -1);
    run_op(5'b00011, 32'h0000_0240, 32'h5, 0, 0, 32'h0000_0240, -1);
    run_op(5'b00010, 32'h0000_0280, 32'h0, 0, -1, 32'h0, 2);

    // AMOADD wraparound
    set_word(32'h0000_0400, 32'hFFFF_FFFF);
    run_op(5'b00000, 32'h0000_0400, 32'h2, 0, -1, 32'h0, -1);
    check("tp_add_rdata", last_rdata, 32'hFFFF_FFFF);
    check("tp_add_wdata", last_wr[31:0], 32'h0000_0001);
    check("tp_add_lat", 32'(last_lat), 32'd3);

    // Signed vs unsigned minimum
    set_word(32'h0000_0500, 32'h8000_0000);
    run_op(5'b10000, 32'h0000_0500, 32'h1, 0, -1, 32'h0, -1);
    check("tp_min_wdata", last_wr[31:0], 32'h8000_0000);
    set_word(32'h0000_0500, 32'h8000_0000);
    run_op(5'b11000, 32'h0000_0500, 32'h1, 1, -1, 32'h0, -1);
    check("tp_minu_wdata", last_wr[31:0], 32'h0000_0001);

    // Error paths: misaligned SWAP and unknown funct5, reservation untouched
    run_op(5'b00010, 32'h0000_1000, 32'h0, 0, -1, 32'h0, -1);
    run_op(5'b00001, 32'h0000_1002, 32'hAAAA_5555, 0, -1, 32'h0, -1);
    check("tp_misalign_err", 32'(last_err), 32'd1);
    check("tp_misalign_lat", 32'(last_lat), 32'd1);
    run_op(5'b11111, 32'h0000_1000, 32'h0, 0, -1, 32'h0, -1);
    check("tp_unknown_err", 32'(last_err), 32'd1);
    check("tp_resv_kept", 32'(dbg_resv_valid), 32'd1);

    // Reset in the middle of a stalled SC write beat
    run_op(5'b00010, 32'h0000_0300, 32'h0, 0, -1, 32'h0, -1);
    ack_delay = 1000;
    req_valid = 1'b1;
    req_funct5 = 5'b00011;
    req_addr  = 32'h0000_0300;
    req_wdata = 32'h7777_8888;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("stall_wr_req", {30'd0, mem_req, mem_we}, 32'd3);
    check("stall_state", 32'(dbg_state), 32'(ST_WR));
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_wr_req", 32'(mem_req), 32'd0);
    check("rst_mid_wr_resv", 32'(dbg_resv_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_rv  = 1'b0;
    ack_delay = 0;
    @(posedge clk);
    #1;
    check("post_rst_writes", 32'(wr_log.size()), 32'd0);
    run_op(5'b00010, 32'h0000_0300, 32'h0, 0, -1, 32'h0, -1);
    check("post_rst_lr_lat", 32'(last_lat), 32'd2);
    run_op(5'b00011, 32'h0000_0300, 32'h9999_0000, 1, -1, 32'h0, -1);

    // Randomized traffic over a small address pool
    for (int i = 0; i < 80; i++) begin
      k  = $urandom_range(0, 15);
      f  = (k < 13) ? op_tab[k] : ((k == 13) ? 5'b11111 : ((k == 14) ? 5'b00101 : 5'b10001));
      a  = addr_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      case ($urandom_range(0, 5))
        0:       wd = 32'h8000_0000;
        1:       wd = 32'h7FFF_FFFF;
        2:       wd = 32'hFFFF_FFFF;
        default: wd = $urandom;
      endcase
      d    = $urandom_range(0, 2);
      s_at = ($urandom_range(0, 3) == 0) ? 0 : -1;
      f_at = ($urandom_range(0, 7) == 0) ? 0 : -1;
      run_op(f, a, wd, d, s_at, addr_pool[$urandom_range(0, 3)], f_at);
      if ($urandom_range(0, 4) == 0)
        idle_cycle(1'b1, addr_pool[$urandom_range(0, 3)], ($urandom_range(0, 5) == 0));
    end

    check("bus_addr_aligned", 32'(bad_align), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
